// File: rtl/matrix_operand_loader_pkg.sv
// Shared constants and types for the matrix multiplier front end.
// Contents:
//   DATA_WIDTH, SIZE, MATRIX_WIDTH  element width, matrix dimension, packed operand width
//   IDX_WIDTH                       width of a row or column index
//   loader_state_t                  operand loader FSM states
package gemm_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int SIZE         = 4;
  localparam int MATRIX_WIDTH = DATA_WIDTH * SIZE * SIZE;
  localparam int IDX_WIDTH    = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    PRESENT
  } loader_state_t;

endpackage

// File: rtl/matrix_operand_loader_if.sv
// Handshake bundle around the operand loader.
// Signals:
//   s_valid, s_ready, s_data, s_last   element stream into the loader
//   m_valid, m_ready                   operand pair handshake out of the loader
//   data0_out, data1_out               packed A (row-major) and B (column-packed)
// Modports:
//   master  the environment: drives the element stream and m_ready
//   slave   the loader itself
interface matrix_operand_loader_if;
  import gemm_pkg::*;

  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_WIDTH-1:0]   s_data;
  logic                    s_last;
  logic                    m_valid;
  logic                    m_ready;
  logic [MATRIX_WIDTH-1:0] data0_out;
  logic [MATRIX_WIDTH-1:0] data1_out;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, data0_out, data1_out
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, data0_out, data1_out
  );

endinterface

// File: rtl/matrix_operand_loader_rc_counter.sv
// Row/column position counter for walking a SIZE x SIZE matrix in row-major order.
// Column advances on every inc; row advances when the column wraps. Both wrap to 0
// after (SIZE-1, SIZE-1). clr has priority over inc.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear of both indices
//   inc         advance one position
//   row, col    current position
//   last        position is (SIZE-1, SIZE-1)
module rc_counter
  import gemm_pkg::*;
#(
  parameter int SIZE_P    = SIZE,
  parameter int IDX_W     = (SIZE_P > 1) ? $clog2(SIZE_P) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(SIZE_P - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == MAX_IDX) begin
        col <= '0;
        row <= (row == MAX_IDX) ? '0 : row + IDX_W'(1);
      end else begin
        col <= col + IDX_W'(1);
      end
    end
  end

  assign last = (row == MAX_IDX) && (col == MAX_IDX);

endmodule

// File: rtl/matrix_operand_loader.sv
// Operand loader for the square matrix multiplier. Collects a frame of
// 2*SIZE*SIZE elements: A row-major into data0_out, then B row-major which is
// stored transposed so column j of B lands in slice j of data1_out. The pair
// is then presented until the consumer takes it. Framing errors drop the frame.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          slave side of matrix_operand_loader_if (stream in, operand pair out)
//   frame_err    one-cycle pulse after a framing violation is accepted
//   tile_count   completed output handshakes, wraps
//
// state   | meaning
// LOAD_A  | accepting A elements, writing data0 slice SIZE*r+c
// LOAD_B  | accepting B elements, writing data1 slice SIZE*c+r
// PRESENT | operand pair valid, input stalled until m_ready
module matrix_operand_loader
  import gemm_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_operand_loader_if.slave bus,
  output logic                 frame_err,
  output logic [CNT_WIDTH-1:0] tile_count
);

  localparam int NUM_ELEM = SIZE * SIZE;

  loader_state_t         state_q;
  loader_state_t         state_d;
  logic                  ready_en_q;
  logic                  accept;
  logic                  in_load;
  logic                  last_pos;
  logic                  cnt_clr;
  logic                  cnt_inc;
  logic                  err_d;
  logic [IDX_WIDTH-1:0]  row;
  logic [IDX_WIDTH-1:0]  col;
  int                    idx_a;
  int                    idx_b;
  logic [MATRIX_WIDTH-1:0] data0_q;
  logic [MATRIX_WIDTH-1:0] data1_q;

  rc_counter #(
    .SIZE_P (SIZE),
    .IDX_W  (IDX_WIDTH)
  ) u_rc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .row   (row),
    .col   (col),
    .last  (last_pos)
  );

  // ready_en_q keeps s_ready low while reset is asserted, since the state
  // register alone would already read LOAD_A during reset.
  assign in_load     = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign bus.s_ready = ready_en_q && in_load;
  assign accept      = bus.s_valid && bus.s_ready;
  assign bus.m_valid = (state_q == PRESENT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD_A;
      ready_en_q <= 1'b0;
      frame_err  <= 1'b0;
      tile_count <= '0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      frame_err  <= err_d;
      if (state_q == PRESENT && bus.m_ready) begin
        tile_count <= tile_count + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      LOAD_A: begin
        if (accept) begin
          // s_last can never be legal inside A.
          if (bus.s_last) begin
            err_d   = 1'b1;
            cnt_clr = 1'b1;
          end else if (last_pos) begin
            state_d = LOAD_B;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          // s_last must coincide exactly with the final B element.
          if (bus.s_last != last_pos) begin
            err_d   = 1'b1;
            state_d = LOAD_A;
            cnt_clr = 1'b1;
          end else if (last_pos) begin
            state_d = PRESENT;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      PRESENT: begin
        if (bus.m_ready) begin
          state_d = LOAD_A;
        end
      end
      default: begin
        state_d = LOAD_A;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_comb begin
    idx_a = SIZE * int'(row) + int'(col);
    idx_b = SIZE * int'(col) + int'(row);
  end

  // Constant-slice write loop keeps each element register a plain enable flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      for (int k = 0; k < NUM_ELEM; k++) begin
        if (accept && state_q == LOAD_A && idx_a == k) begin
          data0_q[k*DATA_WIDTH +: DATA_WIDTH] <= bus.s_data;
        end
        if (accept && state_q == LOAD_B && idx_b == k) begin
          data1_q[k*DATA_WIDTH +: DATA_WIDTH] <= bus.s_data;
        end
      end
    end
  end

  assign bus.data0_out = data0_q;
  assign bus.data1_out = data1_q;

endmodule
